// File: rtl/multicycle_alu.sv
// Registered ALU with a valid/ready request side and a held result side.
// Define MULTICYCLE_ALU_MULDIV_EN to build the iterative unsigned MUL/DIV path.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] fast_next;
    logic             ovf_next;

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign result      = result_reg;
    assign zero        = zero_reg;
    assign overflow    = overflow_reg;
    assign div_by_zero = dbz_reg;

    // Single-cycle results come straight from the inputs and are registered at accept.
    always_comb begin
        sum_next  = a + b;
        diff_next = a - b;
        fast_next = '0;
        ovf_next  = 1'b0;
        case (alu_ct)
            OP_AND: fast_next = a & b;
            OP_OR:  fast_next = a | b;
            OP_NOR: fast_next = ~(a | b);
            OP_SLT: fast_next = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD: begin
                fast_next = sum_next;
                ovf_next  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                fast_next = diff_next;
                ovf_next  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_next[WIDTH-1] != a[WIDTH-1]);
            end
            default: fast_next = '0;
        endcase
    end

`ifdef MULTICYCLE_ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_reg;
    logic             is_div_reg;
    logic [WIDTH-1:0] acc_reg;   // partial product or remainder
    logic [WIDTH-1:0] sh_reg;    // multiplier bits or dividend/quotient bits
    logic [WIDTH-1:0] opa_reg;   // shifted multiplicand
    logic [WIDTH-1:0] opb_reg;   // divisor

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;
    logic [WIDTH-1:0] calc_next;

    always_comb begin
        mul_acc_next = acc_reg + (sh_reg[0] ? opa_reg : '0);
        div_shift    = {acc_reg, sh_reg[WIDTH-1]};
        div_diff     = div_shift - {1'b0, opb_reg};
        div_ge       = ~div_diff[WIDTH];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {sh_reg[WIDTH-2:0], div_ge};
        calc_next    = is_div_reg ? div_quo_next : mul_acc_next;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            dbz_reg      <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            acc_reg      <= '0;
            sh_reg       <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= DONE;
                        result_reg   <= fast_next;
                        zero_reg     <= (fast_next == '0);
                        overflow_reg <= ovf_next;
                        dbz_reg      <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
                        if (alu_ct == OP_MUL || (alu_ct == OP_DIV && b != '0)) begin
                            state_reg  <= CALC;
                            count_reg  <= CW'(WIDTH);
                            is_div_reg <= (alu_ct == OP_DIV);
                            acc_reg    <= '0;
                            sh_reg     <= (alu_ct == OP_DIV) ? a : b;
                            opa_reg    <= a;
                            opb_reg    <= b;
                        end else if (alu_ct == OP_DIV) begin
                            result_reg <= '1;
                            zero_reg   <= 1'b0;
                            dbz_reg    <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
                    count_reg <= count_reg - 1'b1;
                    if (is_div_reg) begin
                        acc_reg <= div_rem_next;
                        sh_reg  <= div_quo_next;
                    end else begin
                        acc_reg <= mul_acc_next;
                        sh_reg  <= sh_reg >> 1;
                        opa_reg <= opa_reg << 1;
                    end
                    // The last iteration's value goes straight into the result register.
                    if (count_reg == CW'(1)) begin
                        state_reg    <= DONE;
                        result_reg   <= calc_next;
                        zero_reg     <= (calc_next == '0);
                        overflow_reg <= 1'b0;
                        dbz_reg      <= 1'b0;
                    end
`else
                    state_reg <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
